ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Latches one decoded instruction and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects register or immediate for operand B and presents registered BusA, BusB and ALUCtrl to the ALU.
- Provides a valid/ready handshake, flush and load-use bubble insertion.

Parameters:
- DataWidth, 64, operand and result width.
- RegAddrWidth, 5, register specifier width.
- ZeroReg, 31, register index that always reads 0 (XZR); never forwarded.
- StallCntWidth, 16, width of the saturating stall counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset_L  input  1  synchronous active-low reset.
- InValid  input  1  decode stage presents an instruction.
- InReady  output  1  stage accepts this cycle.
- RegA  input  DataWidth  register-file read value for Rn.
- RegB  input  DataWidth  register-file read value for Rm.
- Rn  input  RegAddrWidth  source register A.
- Rm  input  RegAddrWidth  source register B.
- Imm  input  DataWidth  sign/zero-extended immediate, or shift amount.
- ALUSrc  input  1  1 selects Imm for BusB; 0 selects forwarded Rm.
- ALUCtrlIn  input  4  ALU operation code.
- RdIn  input  RegAddrWidth  destination register.
- RegWriteIn  input  1  instruction writes Rd.
- Flush  input  1  kill held and incoming instruction.
- ExMemRegWrite  input  1  EX/MEM writes ExMemRd.
- ExMemRd  input  RegAddrWidth  EX/MEM destination.
- ExMemResult  input  DataWidth  EX/MEM ALU result.
- ExMemLoad  input  1  EX/MEM holds a load; its result is not yet available.
- MemWbRegWrite  input  1  MEM/WB writes MemWbRd.
- MemWbRd  input  RegAddrWidth  MEM/WB destination.
- MemWbResult  input  DataWidth  MEM/WB write-back data.
- OutValid  output  1  BusA, BusB and ALUCtrl are valid.
- OutReady  input  1  downstream EX consumes this cycle.
- BusA  output  DataWidth  ALU operand A.
- BusB  output  DataWidth  ALU operand B.
- ALUCtrl  output  4  ALU operation.
- RdOut  output  RegAddrWidth  destination, passed through.
- RegWriteOut  output  1  write enable, passed through.
- FwdSelA  output  2  source used for A at capture: 0 RegA, 1 ExMem, 2 MemWb, 3 zero register.
- FwdSelB  output  2  same encoding for B; 0 when ALUSrc=1.
- StallCount  output  StallCntWidth  cycles with InValid=1 and InReady=0; saturates at all-ones.

Behaviour:
- Reset (Reset_L=0 at a clock edge): OutValid, BusA, BusB, ALUCtrl, RdOut, RegWriteOut, FwdSelA, FwdSelB and StallCount all go to 0. Reset overrides every other input, including a mid-transfer hold.
- Storage is a single entry. State machine has two states:
  - EMPTY: OutValid=0.
  - FULL: OutValid=1.
- Hazard = ExMemLoad & ExMemRegWrite & ExMemRd!=ZeroReg & (ExMemRd==Rn | (!ALUSrc & ExMemRd==Rm)).
- InReady = !Hazard & (!OutValid | OutReady). This is combinational; a full stage refills in the same cycle it drains.
- Capture when InValid & InReady & !Flush. Next state is FULL; the registered outputs update at the edge.
- Latency is 1 cycle from accepted input to OutValid.
- Drain without capture: when OutReady & OutValid and nothing is captured, next state is EMPTY.
- Hold: when FULL & !OutReady, all outputs stay stable.
- Flush: next state is EMPTY and nothing is captured, even if InValid & InReady. Flush wins over simultaneous capture and over OutReady.
- Operand A priority at capture:
  1. Rn==ZeroReg gives 0, sel 3.
  2. ExMemRegWrite & ExMemRd==Rn & !ExMemLoad gives ExMemResult, sel 1.
  3. MemWbRegWrite & MemWbRd==Rn gives MemWbResult, sel 2.
  4. Otherwise RegA, sel 0.
- Operand B: if ALUSrc, Imm. Otherwise the same priority applied to Rm/RegB.
- Forwarding is resolved only at capture. Held operands are not re-evaluated while stalled.
- Hazard cycles create a bubble:
  - If FULL & OutReady, the stage goes EMPTY.
  - If EMPTY, it stays EMPTY.
- StallCount increments on each cycle with InValid & !InReady & !Flush, and saturates at all-ones.
- ALUCtrl passes through unmodified. No arithmetic is performed in this stage.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: ALU_AND=4'h0, ALU_OR=4'h1, ALU_ADD=4'h2, ALU_LSL=4'h3, ALU_LSR=4'h4, ALU_SUB=4'h6, ALU_PASSB=4'h7.
  - FwdSel enum: FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_ZERO.
  - ZERO_REG constant.
- One sub-module, fwd_mux. It is a combinational priority select per operand and is instantiated twice.

Test Plan:
- Basic pass-through:
  - Stimulus: reset low 2 cycles; then Rn=1, Rm=2, RegA=64'h1234, RegB=64'hABCD0000, ALUCtrlIn=4'h2, no forwarding, OutReady=1.
  - Response: next cycle OutValid=1, BusA=64'h1234, BusB=64'hABCD0000, ALUCtrl=2, FwdSelA=FwdSelB=0.
- Forwarding:
  - Stimulus: Rn=5 with ExMemRd=5, ExMemResult=64'h7F0C4B3F, ExMemRegWrite=1; Rm=5 with MemWbRd=5, MemWbResult=64'h5A0E7A39.
  - Response: BusA=64'h7F0C4B3F, sel 1; BusB=64'h7F0C4B3F, sel 1, because EX/MEM has priority.
  - Stimulus: repeat with ExMemRegWrite=0.
  - Response: BusB=64'h5A0E7A39, sel 2.
- Zero register:
  - Stimulus: Rn=31, ExMemRd=31, ExMemRegWrite=1, ExMemResult=64'hFFFF.
  - Response: BusA=0, FwdSelA=3.
- Immediate operand:
  - Stimulus: ALUSrc=1, Imm=64'h7, ALUCtrlIn=4'h4, Rm=ExMemRd=3, ExMemLoad=1.
  - Response: no hazard, InReady=1, BusB=64'h7, FwdSelB=0.
- Load-use bubble:
  - Stimulus: ExMemLoad=1, ExMemRd=Rn=4 for 1 cycle with OutReady=1.
  - Response: InReady=0, OutValid=0 next cycle, StallCount=1. Once ExMemLoad drops, capture proceeds with MemWb forwarding.
- Backpressure, flush and reset:
  - Stimulus: FULL with OutReady=0 for 3 cycles.
  - Response: outputs stable, InReady=0.
  - Stimulus: Flush=1 with InValid=1.
  - Response: OutValid=0 next cycle.
  - Stimulus: Reset_L=0 while FULL.
  - Response: all outputs 0 next edge.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes, forwarding-source encoding and the
//               architectural zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'h0;
   localparam logic [3:0] ALU_OR    = 4'h1;
   localparam logic [3:0] ALU_ADD   = 4'h2;
   localparam logic [3:0] ALU_LSL   = 4'h3;
   localparam logic [3:0] ALU_LSR   = 4'h4;
   localparam logic [3:0] ALU_SUB   = 4'h6;
   localparam logic [3:0] ALU_PASSB = 4'h7;

   // Source chosen for an operand at capture time
   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2,
      FWD_ZERO  = 2'd3
   } fwd_sel_e;

   // XZR: always reads as zero and is never a forwarding target
   localparam int ZERO_REG = 31;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Combinational priority select of one register operand:
//               zero register, then EX/MEM (non-load), then MEM/WB, then RF.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
   import alu_pkg::*;
#(
   parameter int DataWidth    = 64,
   parameter int RegAddrWidth = 5,
   parameter int ZeroReg      = ZERO_REG
) (
   input  logic [RegAddrWidth-1:0] Addr,
   input  logic [DataWidth-1:0]    RegVal,
   input  logic                    ExMemRegWrite,
   input  logic [RegAddrWidth-1:0] ExMemRd,
   input  logic [DataWidth-1:0]    ExMemResult,
   input  logic                    ExMemLoad,
   input  logic                    MemWbRegWrite,
   input  logic [RegAddrWidth-1:0] MemWbRd,
   input  logic [DataWidth-1:0]    MemWbResult,
   output logic [DataWidth-1:0]    Val,
   output fwd_sel_e                Sel
);

   localparam logic [RegAddrWidth-1:0] c_zero_reg = RegAddrWidth'(ZeroReg);

   // Youngest valid producer wins; a pending load in EX/MEM has no data yet
   always_comb begin
      Val = RegVal;
      Sel = FWD_REG;
      if (Addr == c_zero_reg) begin
         Val = '0;
         Sel = FWD_ZERO;
      end else if (ExMemRegWrite && (ExMemRd == Addr) && !ExMemLoad) begin
         Val = ExMemResult;
         Sel = FWD_EXMEM;
      end else if (MemWbRegWrite && (MemWbRd == Addr)) begin
         Val = MemWbResult;
         Sel = FWD_MEMWB;
      end
   end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_operand_stage
// Description : Single-entry ID/EX register feeding the ALU. Resolves operand
//               forwarding at capture, inserts load-use bubbles, supports
//               valid/ready flow control and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
   import alu_pkg::*;
#(
   parameter int DataWidth     = 64,
   parameter int RegAddrWidth  = 5,
   parameter int ZeroReg       = ZERO_REG,
   parameter int StallCntWidth = 16
) (
   input  logic                     CLK,
   input  logic                     Reset_L,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [DataWidth-1:0]     RegA,
   input  logic [DataWidth-1:0]     RegB,
   input  logic [RegAddrWidth-1:0]  Rn,
   input  logic [RegAddrWidth-1:0]  Rm,
   input  logic [DataWidth-1:0]     Imm,
   input  logic                     ALUSrc,
   input  logic [3:0]               ALUCtrlIn,
   input  logic [RegAddrWidth-1:0]  RdIn,
   input  logic                     RegWriteIn,
   input  logic                     Flush,
   input  logic                     ExMemRegWrite,
   input  logic [RegAddrWidth-1:0]  ExMemRd,
   input  logic [DataWidth-1:0]     ExMemResult,
   input  logic                     ExMemLoad,
   input  logic                     MemWbRegWrite,
   input  logic [RegAddrWidth-1:0]  MemWbRd,
   input  logic [DataWidth-1:0]     MemWbResult,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [DataWidth-1:0]     BusA,
   output logic [DataWidth-1:0]     BusB,
   output logic [3:0]               ALUCtrl,
   output logic [RegAddrWidth-1:0]  RdOut,
   output logic                     RegWriteOut,
   output logic [1:0]               FwdSelA,
   output logic [1:0]               FwdSelB,
   output logic [StallCntWidth-1:0] StallCount
);

   localparam logic [RegAddrWidth-1:0] c_zero_reg = RegAddrWidth'(ZeroReg);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic [DataWidth-1:0]     BusA_q, BusB_q;
   logic [3:0]               ALUCtrl_q;
   logic [RegAddrWidth-1:0]  RdOut_q;
   logic                     RegWriteOut_q;
   logic [1:0]               FwdSelA_q, FwdSelB_q;
   logic [StallCntWidth-1:0] StallCount_q;

   logic [DataWidth-1:0] w_fwd_a, w_fwd_b, w_bus_b;
   fwd_sel_e             w_sel_a, w_sel_b_reg, w_sel_b;
   logic                 w_hazard, w_capture, w_stall;

   fwd_mux #(
      .DataWidth    (DataWidth),
      .RegAddrWidth (RegAddrWidth),
      .ZeroReg      (ZeroReg)
   ) u_fwd_a (
      .Addr          (Rn),
      .RegVal        (RegA),
      .ExMemRegWrite (ExMemRegWrite),
      .ExMemRd       (ExMemRd),
      .ExMemResult   (ExMemResult),
      .ExMemLoad     (ExMemLoad),
      .MemWbRegWrite (MemWbRegWrite),
      .MemWbRd       (MemWbRd),
      .MemWbResult   (MemWbResult),
      .Val           (w_fwd_a),
      .Sel           (w_sel_a)
   );

   fwd_mux #(
      .DataWidth    (DataWidth),
      .RegAddrWidth (RegAddrWidth),
      .ZeroReg      (ZeroReg)
   ) u_fwd_b (
      .Addr          (Rm),
      .RegVal        (RegB),
      .ExMemRegWrite (ExMemRegWrite),
      .ExMemRd       (ExMemRd),
      .ExMemResult   (ExMemResult),
      .ExMemLoad     (ExMemLoad),
      .MemWbRegWrite (MemWbRegWrite),
      .MemWbRd       (MemWbRd),
      .MemWbResult   (MemWbResult),
      .Val           (w_fwd_b),
      .Sel           (w_sel_b_reg)
   );

   // An immediate operand B bypasses forwarding and cannot cause a hazard
   assign w_bus_b = ALUSrc ? Imm : w_fwd_b;
   assign w_sel_b = ALUSrc ? FWD_REG : w_sel_b_reg;

   assign w_hazard = ExMemLoad && ExMemRegWrite && (ExMemRd != c_zero_reg) &&
                     ((ExMemRd == Rn) || (!ALUSrc && (ExMemRd == Rm)));

   assign OutValid  = (state_q == FULL);
   assign InReady   = !w_hazard && (!OutValid || OutReady);
   assign w_capture = InValid && InReady && !Flush;
   assign w_stall   = InValid && !InReady && !Flush;

   // Next state: flush dominates, then capture, then drain; otherwise hold
   always_comb begin
      state_d = state_q;
      if (Flush) begin
         state_d = EMPTY;
      end else if (w_capture) begin
         state_d = FULL;
      end else if (OutValid && OutReady) begin
         state_d = EMPTY;
      end
   end

   // State register, captured operands and saturating stall counter
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state_q       <= EMPTY;
         BusA_q        <= '0;
         BusB_q        <= '0;
         ALUCtrl_q     <= '0;
         RdOut_q       <= '0;
         RegWriteOut_q <= 1'b0;
         FwdSelA_q     <= '0;
         FwdSelB_q     <= '0;
         StallCount_q  <= '0;
      end else begin
         state_q <= state_d;
         if (w_capture) begin
            BusA_q        <= w_fwd_a;
            BusB_q        <= w_bus_b;
            ALUCtrl_q     <= ALUCtrlIn;
            RdOut_q       <= RdIn;
            RegWriteOut_q <= RegWriteIn;
            FwdSelA_q     <= w_sel_a;
            FwdSelB_q     <= w_sel_b;
         end
         if (w_stall && (StallCount_q != '1)) begin
            StallCount_q <= StallCount_q + 1'b1;
         end
      end
   end

   assign BusA        = BusA_q;
   assign BusB        = BusB_q;
   assign ALUCtrl     = ALUCtrl_q;
   assign RdOut       = RdOut_q;
   assign RegWriteOut = RegWriteOut_q;
   assign FwdSelA     = FwdSelA_q;
   assign FwdSelB     = FwdSelB_q;
   assign StallCount  = StallCount_q;

endmodule : ex_operand_stage
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_operand_stage
// Description : Directed self-checking bench for ex_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic        InValid;
   logic        InReady;
   logic [63:0] RegA, RegB, Imm;
   logic [4:0]  Rn, Rm, RdIn;
   logic        ALUSrc;
   logic [3:0]  ALUCtrlIn;
   logic        RegWriteIn;
   logic        Flush;
   logic        ExMemRegWrite;
   logic [4:0]  ExMemRd;
   logic [63:0] ExMemResult;
   logic        ExMemLoad;
   logic        MemWbRegWrite;
   logic [4:0]  MemWbRd;
   logic [63:0] MemWbResult;
   logic        OutValid;
   logic        OutReady;
   logic [63:0] BusA, BusB;
   logic [3:0]  ALUCtrl;
   logic [4:0]  RdOut;
   logic        RegWriteOut;
   logic [1:0]  FwdSelA, FwdSelB;
   logic [15:0] StallCount;

   int checks = 0;
   int errors = 0;

   ex_operand_stage dut (
      .CLK           (CLK),
      .Reset_L       (Reset_L),
      .InValid       (InValid),
      .InReady       (InReady),
      .RegA          (RegA),
      .RegB          (RegB),
      .Rn            (Rn),
      .Rm            (Rm),
      .Imm           (Imm),
      .ALUSrc        (ALUSrc),
      .ALUCtrlIn     (ALUCtrlIn),
      .RdIn          (RdIn),
      .RegWriteIn    (RegWriteIn),
      .Flush         (Flush),
      .ExMemRegWrite (ExMemRegWrite),
      .ExMemRd       (ExMemRd),
      .ExMemResult   (ExMemResult),
      .ExMemLoad     (ExMemLoad),
      .MemWbRegWrite (MemWbRegWrite),
      .MemWbRd       (MemWbRd),
      .MemWbResult   (MemWbResult),
      .OutValid      (OutValid),
      .OutReady      (OutReady),
      .BusA          (BusA),
      .BusB          (BusB),
      .ALUCtrl       (ALUCtrl),
      .RdOut         (RdOut),
      .RegWriteOut   (RegWriteOut),
      .FwdSelA       (FwdSelA),
      .FwdSelB       (FwdSelB),
      .StallCount    (StallCount)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      Reset_L = 1'b0; InValid = 1'b0; RegA = '0; RegB = '0; Imm = '0;
      Rn = '0; Rm = '0; RdIn = '0; ALUSrc = 1'b0; ALUCtrlIn = '0;
      RegWriteIn = 1'b0; Flush = 1'b0; ExMemRegWrite = 1'b0; ExMemRd = '0;
      ExMemResult = '0; ExMemLoad = 1'b0; MemWbRegWrite = 1'b0; MemWbRd = '0;
      MemWbResult = '0; OutReady = 1'b1;

      // Reset
      tick(); tick();
      chk("rst_valid", 64'(OutValid), 64'd0);
      chk("rst_busa", BusA, 64'd0);
      chk("rst_busb", BusB, 64'd0);
      chk("rst_ctrl", 64'(ALUCtrl), 64'd0);
      chk("rst_stall", 64'(StallCount), 64'd0);

      // Basic pass-through
      Reset_L = 1'b1; InValid = 1'b1; Rn = 5'd1; Rm = 5'd2;
      RegA = 64'h1234; RegB = 64'hABCD0000; ALUCtrlIn = 4'h2;
      RdIn = 5'd7; RegWriteIn = 1'b1;
      #1 chk("basic_inready", 64'(InReady), 64'd1);
      tick();
      chk("basic_valid", 64'(OutValid), 64'd1);
      chk("basic_busa", BusA, 64'h1234);
      chk("basic_busb", BusB, 64'hABCD0000);
      chk("basic_ctrl", 64'(ALUCtrl), 64'd2);
      chk("basic_sela", 64'(FwdSelA), 64'd0);
      chk("basic_selb", 64'(FwdSelB), 64'd0);
      chk("basic_rd", 64'(RdOut), 64'd7);
      chk("basic_we", 64'(RegWriteOut), 64'd1);

      // EX/MEM beats MEM/WB
      Rn = 5'd5; Rm = 5'd5;
      ExMemRegWrite = 1'b1; ExMemRd = 5'd5; ExMemResult = 64'h7F0C4B3F;
      MemWbRegWrite = 1'b1; MemWbRd = 5'd5; MemWbResult = 64'h5A0E7A39;
      tick();
      chk("fwd_ex_busa", BusA, 64'h7F0C4B3F);
      chk("fwd_ex_sela", 64'(FwdSelA), 64'd1);
      chk("fwd_ex_busb", BusB, 64'h7F0C4B3F);
      chk("fwd_ex_selb", 64'(FwdSelB), 64'd1);

      // MEM/WB when EX/MEM is not writing
      ExMemRegWrite = 1'b0;
      tick();
      chk("fwd_wb_busa", BusA, 64'h5A0E7A39);
      chk("fwd_wb_sela", 64'(FwdSelA), 64'd2);
      chk("fwd_wb_busb", BusB, 64'h5A0E7A39);
      chk("fwd_wb_selb", 64'(FwdSelB), 64'd2);

      // Zero register is never forwarded
      Rn = 5'd31; Rm = 5'd2; ExMemRd = 5'd31; ExMemRegWrite = 1'b1;
      ExMemResult = 64'hFFFF; MemWbRegWrite = 1'b0; MemWbRd = 5'd0;
      tick();
      chk("zero_busa", BusA, 64'd0);
      chk("zero_sela", 64'(FwdSelA), 64'd3);
      chk("zero_busb", BusB, 64'hABCD0000);
      chk("zero_selb", 64'(FwdSelB), 64'd0);

      // Immediate operand hides a load on Rm
      Rn = 5'd1; Rm = 5'd3; ALUSrc = 1'b1; Imm = 64'h7; ALUCtrlIn = 4'h4;
      ExMemRd = 5'd3; ExMemLoad = 1'b1; ExMemRegWrite = 1'b1;
      #1 chk("imm_inready", 64'(InReady), 64'd1);
      tick();
      chk("imm_busb", BusB, 64'h7);
      chk("imm_selb", 64'(FwdSelB), 64'd0);
      chk("imm_busa", BusA, 64'h1234);
      chk("imm_ctrl", 64'(ALUCtrl), 64'd4);

      // Load-use bubble
      ALUSrc = 1'b0; Rn = 5'd4; Rm = 5'd2; ExMemRd = 5'd4; ALUCtrlIn = 4'h2;
      #1 chk("lu_inready", 64'(InReady), 64'd0);
      tick();
      chk("lu_valid", 64'(OutValid), 64'd0);
      chk("lu_stall", 64'(StallCount), 64'd1);

      // Load result now in MEM/WB
      ExMemLoad = 1'b0; ExMemRegWrite = 1'b0;
      MemWbRegWrite = 1'b1; MemWbRd = 5'd4; MemWbResult = 64'hDEADBEEF;
      #1 chk("lu2_inready", 64'(InReady), 64'd1);
      tick();
      chk("lu2_valid", 64'(OutValid), 64'd1);
      chk("lu2_busa", BusA, 64'hDEADBEEF);
      chk("lu2_sela", 64'(FwdSelA), 64'd2);
      chk("lu2_stall", 64'(StallCount), 64'd1);

      // Backpressure: held operands not re-evaluated
      OutReady = 1'b0; MemWbResult = 64'h1111; RegA = 64'h2222;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_inready", 64'(InReady), 64'd0);
         tick();
         chk("bp_valid", 64'(OutValid), 64'd1);
         chk("bp_busa", BusA, 64'hDEADBEEF);
         chk("bp_ctrl", 64'(ALUCtrl), 64'd2);
      end
      chk("bp_stall", 64'(StallCount), 64'd4);

      // Flush beats hold; stall count frozen while flushing
      Flush = 1'b1;
      tick();
      chk("fl_valid", 64'(OutValid), 64'd0);
      chk("fl_stall", 64'(StallCount), 64'd4);
      // Flush beats capture even with InReady high
      OutReady = 1'b1;
      #1 chk("fl2_inready", 64'(InReady), 64'd1);
      tick();
      chk("fl2_valid", 64'(OutValid), 64'd0);

      // Refill, then drain without capture
      Flush = 1'b0; Rn = 5'd1; MemWbRegWrite = 1'b0;
      tick();
      chk("rf_valid", 64'(OutValid), 64'd1);
      chk("rf_busa", BusA, 64'h2222);
      InValid = 1'b0;
      tick();
      chk("dr_valid", 64'(OutValid), 64'd0);

      // Reset while full and held
      InValid = 1'b1;
      tick();
      chk("rf2_valid", 64'(OutValid), 64'd1);
      OutReady = 1'b0; Reset_L = 1'b0;
      tick();
      chk("rst2_valid", 64'(OutValid), 64'd0);
      chk("rst2_busa", BusA, 64'd0);
      chk("rst2_busb", BusB, 64'd0);
      chk("rst2_we", 64'(RegWriteOut), 64'd0);
      chk("rst2_rd", 64'(RdOut), 64'd0);
      chk("rst2_sela", 64'(FwdSelA), 64'd0);
      chk("rst2_stall", 64'(StallCount), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ex_operand_stage
`default_nettype wire
